// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master and slave: frame width, CS idle level, FSM states.
package spi_pkg;

    localparam int   SPI_WIDTH = 8;
    localparam logic CS_IDLE   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slave_rx_tx_sync.sv
// N-stage flip-flop synchronizer with a configurable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Oversampling SPI slave: LSB-first frames both ways, single-entry reply buffer.
// Data is sampled on SCLK falls; a rise in DONE starts a back-to-back frame.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCLK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_empty,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             underrun
);

    localparam int CW = $clog2(WIDTH + 1);

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0))    u_sync_sclk (.clk(clk), .rst(reset), .d(SCLK), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs   (.clk(clk), .rst(reset), .d(CS),   .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0))    u_sync_mosi (.clk(clk), .rst(reset), .d(MOSI), .q(mosi_s));

    spi_state_t       state_q, state_d;
    logic             sclk_prev_q, sclk_prev_d;
    logic             cs_prev_q, cs_prev_d;
    logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic             tx_empty_q, tx_empty_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic             busy_q, busy_d;

    logic sclk_fall, sclk_rise, cs_fall, cs_rise, frame_start;

    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;

    always_comb begin
        state_d     = state_q;
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        tx_buf_d    = tx_buf_q;
        tx_empty_d  = tx_empty_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = underrun_q;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                // A CS rise wins over frame completion so an aborted frame never reports
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (bit_cnt_q == CW'(WIDTH)) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (sclk_fall) begin
                    rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
                    tx_shift_d = {1'b0, tx_shift_q[WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise && !cs_s) begin
                    frame_start = 1'b1;
                    state_d     = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            tx_shift_d = tx_empty_q ? '0 : tx_buf_q;
            underrun_d = underrun_q | tx_empty_q;
            tx_empty_d = 1'b1;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
        end

        // A load in the same cycle as the frame-start copy stays buffered for the next frame
        if (tx_load) begin
            tx_buf_d   = tx_data;
            tx_empty_d = 1'b0;
        end

        busy_d    = (state_q == SHIFT);
        miso_oe_d = (state_q != IDLE);
        miso_d    = (state_q == SHIFT) ? tx_shift_q[0] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= CS_IDLE;
            tx_buf_q    <= '0;
            tx_empty_q  <= 1'b1;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_oe  = miso_oe_q;
    assign tx_empty = tx_empty_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: table-driven frames plus abort, back-to-back, underrun and reset cases.
module tb_spi_slave_rx_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCLK, CS, MOSI;
    logic       MISO, MISO_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid, busy, underrun;

    spi_slave_rx_tx dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_empty(tx_empty), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fall_cyc = 0;
    int rxv_cnt = 0;
    int rxv_cyc = 0;
    int dbl     = 0;
    logic rxv_prev = 1'b0;
    logic [7:0] rx_last = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt = rxv_cnt + 1;
            rxv_cyc = cyc;
            rx_last = rx_data;
            if (rxv_prev) dbl = dbl + 1;
        end
        rxv_prev = (rx_valid === 1'b1);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        CS = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        CS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Master drives MOSI on the rise and samples MISO at the end of the high phase
    task automatic shift_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            SCLK = 1'b1;
            MOSI = mo[i];
            repeat (5) @(negedge clk);
            mi[i] = MISO;
            SCLK = 1'b0;
            fall_cyc = cyc;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic wait_rxv(input int base);
        for (int k = 0; k < 20 && rxv_cnt == base; k++) @(negedge clk);
        check("rx_valid_count", rxv_cnt, base + 1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] mi, m1, m2;
        int base, lat;

        vecs[0] = '{tx: 8'h3C, mosi: 8'hA5, exp_rx: 8'hA5, exp_miso: 8'h3C};
        vecs[1] = '{tx: 8'hFF, mosi: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{tx: 8'h00, mosi: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{tx: 8'h81, mosi: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81};
        vecs[4] = '{tx: 8'h5A, mosi: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h5A};

        reset = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_MISO",     MISO, 0);
        check("reset_MISO_oe",  MISO_oe, 0);
        check("reset_rx_data",  rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_busy",     busy, 0);
        check("reset_tx_empty", tx_empty, 1);
        check("reset_underrun", underrun, 0);

        for (int v = 0; v < 5; v++) begin
            base = rxv_cnt;
            load(vecs[v].tx);
            check("tx_empty_after_load", tx_empty, 0);
            cs_low();
            check("busy_in_frame", busy, 1);
            check("oe_in_frame", MISO_oe, 1);
            shift_bits(vecs[v].mosi, 8, mi);
            wait_rxv(base);
            check("vec_rx_data", rx_last, vecs[v].exp_rx);
            check("vec_miso_byte", mi, vecs[v].exp_miso);
            check("vec_rx_valid_latency", rxv_cyc - fall_cyc, 4);
            check("vec_underrun", underrun, 0);
            cs_high();
            check("vec_tx_empty_after", tx_empty, 1);
            check("vec_oe_after", MISO_oe, 0);
        end

        // Abort after five falls
        base = rxv_cnt;
        load(8'h77);
        @(negedge clk);
        CS = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (busy === 1'b1) lat = k;
        end
        check("busy_rise_latency", lat, 4);
        repeat (4) @(negedge clk);
        shift_bits(8'hF0, 5, mi);
        @(negedge clk);
        CS = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_busy_low", busy, 0);
        repeat (10) @(negedge clk);
        check("abort_no_rx_valid", rxv_cnt, base);
        check("abort_rx_data_kept", rx_data, 8'hC3);
        check("abort_tx_consumed", tx_empty, 1);

        // Back-to-back frames without CS rising
        base = rxv_cnt;
        load(8'h11);
        cs_low();
        shift_bits(8'h22, 8, m1);
        wait_rxv(base);
        check("b2b_rx_first", rx_last, 8'h22);
        load(8'h33);
        shift_bits(8'h44, 8, m2);
        wait_rxv(base + 1);
        check("b2b_rx_second", rx_last, 8'h44);
        check("b2b_miso_first", m1, 8'h11);
        check("b2b_miso_second", m2, 8'h33);
        check("b2b_underrun", underrun, 0);
        cs_high();

        // Underrun: frame with nothing loaded, then a normal frame
        base = rxv_cnt;
        cs_low();
        shift_bits(8'h5A, 8, mi);
        wait_rxv(base);
        check("underrun_miso", mi, 8'h00);
        check("underrun_rx", rx_last, 8'h5A);
        check("underrun_set", underrun, 1);
        cs_high();
        base = rxv_cnt;
        load(8'hC6);
        cs_low();
        shift_bits(8'h3B, 8, mi);
        wait_rxv(base);
        check("after_underrun_miso", mi, 8'hC6);
        check("after_underrun_rx", rx_last, 8'h3B);
        check("underrun_sticky", underrun, 1);
        cs_high();

        // Reset in the middle of a frame
        base = rxv_cnt;
        load(8'hE7);
        cs_low();
        shift_bits(8'h99, 4, mi);
        @(negedge clk);
        reset = 1'b1;
        CS = 1'b1;
        #2;
        check("midreset_busy", busy, 0);
        check("midreset_oe", MISO_oe, 0);
        check("midreset_underrun", underrun, 0);
        check("midreset_tx_empty", tx_empty, 1);
        check("midreset_rx_data", rx_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midreset_no_rx_valid", rxv_cnt, base);
        load(8'h96);
        cs_low();
        shift_bits(8'h69, 8, mi);
        wait_rxv(base);
        check("post_reset_rx", rx_last, 8'h69);
        check("post_reset_miso", mi, 8'h96);
        check("post_reset_underrun", underrun, 0);
        cs_high();

        check("rx_valid_single_cycle", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
